tablero_stream: RTL and testbench

TABLERO_STREAM -- requirements
Module: tablero_stream

---
 rtl/tablero_stream.sv | 139 +++++++++++++
 tb/tb_tablero_stream.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tablero_stream.sv
// Board of ROWS x COLS cells with a write port; start snapshots the board and streams it out.
// First beat 1 cycle after start, then one beat per out_ready cycle; a beat is held stable while out_ready is low.
module tablero_stream #(
    parameter  int ROWS      = 5,
    parameter  int COLS      = 5,
    parameter  int W         = 8,
    parameter  int COL_MAJOR = 0,
    localparam int N         = ROWS * COLS,
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [RW-1:0]         wr_row,
    input  logic [CW-1:0]         wr_col,
    input  logic [W-1:0]          wr_data,
    input  logic                  start,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_data,
    output logic [IW-1:0]         out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [N-1:0][W-1:0]   states
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t               state_q, state_d;
    logic [N-1:0][W-1:0]  live_q, live_d;
    logic [N-1:0][W-1:0]  snap_q, snap_d;
    logic [IW-1:0]        k_q, k_d;
    logic [RW-1:0]        r_q, r_d;
    logic [CW-1:0]        c_q, c_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 wr_hit;
    logic [IW-1:0]        wr_idx;
    logic [IW-1:0]        rd_idx;

    assign wr_hit = wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
    assign wr_idx = IW'(int'(wr_row) * COLS + int'(wr_col));
    // Separate row/col scan counters avoid a divider for column-major order.
    assign rd_idx = IW'(int'(r_q) * COLS + int'(c_q));

    always_comb begin
        live_d = live_q;
        if (clr) begin
            live_d = '0;
        end else if (wr_hit) begin
            live_d[wr_idx] = wr_data;
        end

        snap_d  = snap_q;
        state_d = state_q;
        k_d     = k_q;
        r_d     = r_q;
        c_d     = c_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = live_q;
                    k_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    if (k_q == IW'(N - 1)) begin
                        state_d = DONE;
                    end else begin
                        k_d = k_q + 1'b1;
                        if (COL_MAJOR != 0) begin
                            if (r_q == RW'(ROWS - 1)) begin
                                r_d = '0;
                                c_d = c_q + 1'b1;
                            end else begin
                                r_d = r_q + 1'b1;
                            end
                        end else begin
                            if (c_q == CW'(COLS - 1)) begin
                                c_d = '0;
                                r_d = r_q + 1'b1;
                            end else begin
                                c_d = c_q + 1'b1;
                            end
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == SCAN);
        busy_d      = (state_d == SCAN);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            live_q      <= '0;
            snap_q      <= '0;
            k_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            live_q      <= live_d;
            snap_q      <= snap_d;
            k_q         <= k_d;
            r_q         <= r_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_index = k_q;
    assign out_data  = snap_q[rd_idx];
    assign out_last  = out_valid_q && (k_q == IW'(N - 1));
    assign states    = live_q;

endmodule

// File: tb/tb_tablero_stream.sv
// Bench: row-major and column-major instances share stimulus; a scoreboard per instance checks every beat.
module tb_tablero_stream;
    localparam int ROWS = 5;
    localparam int COLS = 5;
    localparam int W    = 8;
    localparam int N    = ROWS * COLS;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clr = 1'b0;
    logic                 wr_en = 1'b0;
    logic [2:0]           wr_row = '0;
    logic [2:0]           wr_col = '0;
    logic [W-1:0]         wr_data = '0;
    logic                 start = 1'b0;
    logic                 out_ready = 1'b0;
    logic [1:0]           v, l, busy, done;
    logic [1:0][W-1:0]    d;
    logic [1:0][4:0]      idx;
    logic [N-1:0][W-1:0]  st0, st1;

    typedef struct packed {
        logic [W-1:0] d;
        logic [4:0]   i;
        logic         l;
    } item_t;

    item_t      q0[$];
    item_t      q1[$];
    logic [W-1:0] board [N];
    int         checks = 0;
    int         errors = 0;
    int         beats [2];
    int         dones [2];
    logic       stall [2];
    item_t      held [2];

    tablero_stream #(.ROWS(ROWS), .COLS(COLS), .W(W), .COL_MAJOR(0)) dut_rm (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .start(start), .out_valid(v[0]), .out_ready(out_ready),
        .out_data(d[0]), .out_index(idx[0]), .out_last(l[0]), .busy(busy[0]), .done(done[0]),
        .states(st0));

    tablero_stream #(.ROWS(ROWS), .COLS(COLS), .W(W), .COL_MAJOR(1)) dut_cm (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .start(start), .out_valid(v[1]), .out_ready(out_ready),
        .out_data(d[1]), .out_index(idx[1]), .out_last(l[1]), .busy(busy[1]), .done(done[1]),
        .states(st1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_scan();
        for (int k = 0; k < N; k++) begin
            q0.push_back({board[k], 5'(k), k == N - 1});
            q1.push_back({board[(k % ROWS) * COLS + k / ROWS], 5'(k), k == N - 1});
        end
    endtask

    task automatic wr(input int r, input int c, input int dat);
        wr_en   = 1'b1;
        wr_row  = 3'(r);
        wr_col  = 3'(c);
        wr_data = 8'(dat);
        step();
        wr_en = 1'b0;
        if (r < ROWS && c < COLS) board[r * COLS + c] = 8'(dat);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((busy != 0 || done != 0 || v != 0) && n < lim) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(n < lim), 1);
        step();
    endtask

    always @(negedge clk) begin : mon
        item_t e;
        item_t cur;
        int    qs;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                stall[i] = 1'b0;
            end else begin
                cur = {d[i], idx[i], l[i]};
                if (stall[i]) begin
                    chk("hold_vld", 32'(v[i]), 1);
                    chk("hold_beat", 32'(cur), 32'(held[i]));
                end
                if (v[i] && out_ready) begin
                    qs = (i == 0) ? q0.size() : q1.size();
                    chk("beat_expected", 32'(qs > 0), 1);
                    if (qs > 0) begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk(i == 0 ? "beat_rm" : "beat_cm", 32'(cur), 32'(e));
                    end
                    beats[i]++;
                end
                if (done[i]) dones[i]++;
                stall[i] = v[i] && !out_ready;
                held[i]  = cur;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1, dn0, dn1, n;
        for (int k = 0; k < N; k++) board[k] = '0;
        for (int i = 0; i < 2; i++) begin
            beats[i] = 0; dones[i] = 0; stall[i] = 1'b0; held[i] = '0;
        end

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", 32'(v), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_last", 32'(l), 0);
        chk("rst_data", 32'(d), 0);
        chk("rst_index", 32'(idx), 0);
        chk("rst_states", 32'((|st0) | (|st1)), 0);

        // Start accepted on the first edge after reset release
        rst_n = 1'b1;
        start = 1'b1;
        out_ready = 1'b1;
        push_scan();
        step();
        start = 1'b0;
        @(negedge clk);
        chk("first_edge_vld", 32'(v), 32'(2'b11));
        wait_idle(100);

        // Row/column-major streams of cell(r,c) = r*5+c, constant ready
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                wr(r, c, r * 5 + c);
        start = 1'b1;
        push_scan();
        step();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("no_bubble", 32'(v), 32'(2'b11));
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'(2'b11));
        chk("done_busy", 32'(busy), 0);
        chk("done_vld", 32'(v), 0);
        step();
        chk("done_one_cycle", 32'(done), 0);
        chk("q_empty_a", 32'(q0.size() + q1.size()), 0);

        // Same-cycle start + write streams old value; clr mid-scan only hits live cells
        start = 1'b1;
        push_scan();
        wr(0, 0, 8'hAA);
        start = 1'b0;
        step();
        chk("wr_live_rm", 32'(st0[0]), 32'h0AA);
        chk("wr_live_cm", 32'(st1[0]), 32'h0AA);
        clr = 1'b1;
        wr(2, 2, 8'h55);
        clr = 1'b0;
        for (int k = 0; k < N; k++) board[k] = '0;
        chk("clr_states", 32'((|st0) | (|st1)), 0);
        wait_idle(100);
        chk("clr_states_end", 32'((|st0) | (|st1)), 0);
        chk("q_empty_b", 32'(q0.size() + q1.size()), 0);

        // Random backpressure
        for (int k = 0; k < N; k++) wr(k / COLS, k % COLS, $urandom_range(0, 255));
        b0 = beats[0]; b1 = beats[1]; dn0 = dones[0]; dn1 = dones[1];
        start = 1'b1;
        push_scan();
        step();
        start = 1'b0;
        n = 0;
        while (busy != 0 && n < 500) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk("bp_timeout", 32'(n < 500), 1);
        out_ready = 1'b1;
        step();
        step();
        chk("bp_beats_rm", 32'(beats[0] - b0), N);
        chk("bp_beats_cm", 32'(beats[1] - b1), N);
        chk("bp_done_rm", 32'(dones[0] - dn0), 1);
        chk("bp_done_cm", 32'(dones[1] - dn1), 1);
        chk("q_empty_c", 32'(q0.size() + q1.size()), 0);

        // Reset mid-scan
        b0 = beats[0]; dn0 = dones[0]; dn1 = dones[1];
        start = 1'b1;
        push_scan();
        step();
        start = 1'b0;
        n = 0;
        while (beats[0] < b0 + 10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_timeout", 32'(n < 100), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_vld", 32'(v), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_states", 32'((|st0) | (|st1)), 0);
        q0.delete();
        q1.delete();
        for (int k = 0; k < N; k++) board[k] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("abort_no_done", 32'((dones[0] - dn0) + (dones[1] - dn1)), 0);
        wr(1, 3, 8'h3C);
        wr(4, 0, 8'hC3);
        start = 1'b1;
        push_scan();
        step();
        start = 1'b0;
        @(negedge clk);
        chk("restart_index", 32'(idx), 0);
        wait_idle(100);
        chk("q_empty_d", 32'(q0.size() + q1.size()), 0);

        // Out-of-range writes ignored; start during SCAN ignored
        wr(7, 0, 8'h77);
        wr(0, 6, 8'h66);
        wr(5, 4, 8'h11);
        for (int k = 0; k < N; k++) begin
            chk("oor_rm", 32'(st0[k]), 32'(board[k]));
            chk("oor_cm", 32'(st1[k]), 32'(board[k]));
        end
        b0 = beats[0]; b1 = beats[1]; dn0 = dones[0];
        start = 1'b1;
        push_scan();
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle(100);
        repeat (5) step();
        chk("ign_beats_rm", 32'(beats[0] - b0), N);
        chk("ign_beats_cm", 32'(beats[1] - b1), N);
        chk("ign_done", 32'(dones[0] - dn0), 1);
        chk("q_empty_e", 32'(q0.size() + q1.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
